vedic_seq_mul: RTL and testbench
================================

Name: vedic_seq_mul

Overview:
- Multi-cycle unsigned multiplier that time-shares one combinational 3x3 Urdhva-Tiryakbhyam core to form a DW x DW product, DW = K*CW.
- Splits each operand into K digits of CW bits and issues one digit-pair product per cycle (K*K passes), shift-accumulating into a 2*DW result.
- Sits between an upstream operand source and downstream consumer, with valid/ready handshakes on both sides.

Parameters:
- CW, 3, core digit width; must equal the 3x3 core width (only 3 supported).
- K, 2, digits per operand; DW = K*CW (default 6); passes per operation = K*K.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  DW  multiplicand, unsigned
- in_b  in  DW  multiplier, unsigned
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*DW  product in_a*in_b
- busy  out  1  operation in flight (state != IDLE)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-low. While rst_n=0 at a rising edge: state=IDLE, acc=0, pass index=0, operand regs=0. Resulting outputs: in_ready=1, out_valid=0, out_p=0, busy=0.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready at an edge latches in_a/in_b, clears acc, sets idx=0 and moves to MUL.
  - MUL: in_ready=0, busy=1. Each cycle, digit i=idx/K of a and digit j=idx%K of b (digit 0 = LSBs) drive the core. At the edge: acc += core_p << ((i+j)*CW); idx += 1. When idx==K*K-1, the accumulate completes and the state moves to DONE.
  - DONE: out_valid=1, out_p=acc, busy=1. out_ready at an edge moves to IDLE. Without out_ready, out_p holds stable indefinitely.
- Pass order is fixed: i outer, j inner, ascending (K=2: aL*bL, aL*bH, aH*bL, aH*bH).
- Latency: out_valid rises K*K cycles after the accept edge (4 for K=2). Throughput is one operation per K*K+2 cycles when out_ready is held high. There is no accept in the same cycle as DONE->IDLE.
- Arithmetic:
  - acc width 2*DW; the maximum product (2^DW-1)^2 fits, so no overflow is possible.
  - Core output is 2*CW bits, zero-extended before shifting.
  - All operations are unsigned.
- out_p is driven by acc in every state, but is only meaningful when out_valid=1. Consumers must ignore it otherwise.
- in_a/in_b are sampled only at the accept edge. Later changes to them during MUL/DONE have no effect.
- in_valid asserted outside IDLE is ignored (in_ready=0). The source must hold in_valid and its operands until accepted.
- Reset mid-operation: rst_n=0 in MUL or DONE aborts the operation. No out_valid is produced for the aborted operands. The block returns to IDLE next cycle with all reset values.
- Zero operands still take the full K*K passes; there is no early termination.

Decomposition:
- Shared header/package vedic_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_MUL=2'd1, ST_DONE=2'd2 (2'd3 unreachable, decodes to IDLE);
  - CW default;
  - helper for pass count K*K and index width clog2(K*K).
- Sub-module vedic_mul3x3: purely combinational 3x3 Urdhva core (a[2:0], b[2:0] -> p[5:0]) built from half/full-adder cells. Exactly one instance; this block owns the sequencing, operand muxing, shifter and accumulator.

Test Plan:
- Reset, then 45*27 with out_ready=1 -> out_valid exactly 4 cycles after accept, out_p=1215, one-cycle out_valid pulse, in_ready back high 1 cycle later.
- Corners 0*63, 63*0, 1*1, 63*63 -> out_p 0, 0, 1, 3969; every operation takes 4 MUL cycles.
- Backpressure: 5*7 with out_ready=0 for 10 cycles -> out_valid=1 and out_p=35 stable throughout, in_ready=0, new in_valid/in_a changes ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-operation: accept 50*50, assert rst_n=0 during the 2nd MUL cycle -> next cycle IDLE, out_valid=0, out_p=0; then 3*4 -> out_p=12, with no stale contribution.
- Back-to-back: in_valid held with 3 queued pairs (10*10, 63*1, 33*22), out_ready=1 -> results 100, 63, 726 in order, spaced 6 cycles apart.
- Random: 1000 random 6-bit pairs with random out_ready stalls -> every out_p equals the reference product; no drops or duplicates.

Source files
------------

// File: rtl/vedic_seq_mul_pkg.sv
// Shared definitions for the sequential Vedic multiplier: FSM states,
// default core width, pass-count helpers and adder cells for the 3x3 core.
package vedic_pkg;

    localparam int unsigned CW_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned pass_count(input int unsigned k);
        return k * k;
    endfunction

    function automatic int unsigned idx_width(input int unsigned k);
        return (k * k > 1) ? $clog2(k * k) : 1;
    endfunction

    // {carry, sum}
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
    endfunction

endpackage

// File: rtl/vedic_seq_mul_if.sv
// Operand/product valid-ready handshake bundle for vedic_seq_mul.
interface vedic_seq_mul_if #(
    parameter int unsigned DW = 6
);
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a;
    logic [DW-1:0]   in_b;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/vedic_seq_mul_mul3x3.sv
// Combinational 3x3 Urdhva-Tiryakbhyam multiplier: vertical/crosswise
// partial products reduced column by column with half/full adders.
module vedic_mul3x3
    import vedic_pkg::*;
(
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    output logic [5:0] o_p
);
    logic [1:0] w_c1, w_c2a, w_c2b, w_c3a, w_c3b, w_c4;

    always_comb begin
        w_c1  = ha(i_a[1] & i_b[0], i_a[0] & i_b[1]);
        w_c2a = fa(i_a[2] & i_b[0], i_a[1] & i_b[1], i_a[0] & i_b[2]);
        w_c2b = ha(w_c2a[0], w_c1[1]);
        w_c3a = fa(i_a[2] & i_b[1], i_a[1] & i_b[2], w_c2a[1]);
        w_c3b = ha(w_c3a[0], w_c2b[1]);
        w_c4  = fa(i_a[2] & i_b[2], w_c3a[1], w_c3b[1]);
        o_p   = {w_c4[1], w_c4[0], w_c3b[0], w_c2b[0], w_c1[0], i_a[0] & i_b[0]};
    end
endmodule

// File: rtl/vedic_seq_mul.sv
// Multi-cycle DW x DW unsigned multiplier time-sharing one 3x3 Vedic core,
// one digit-pair product per cycle shift-accumulated into a 2*DW result.
module vedic_seq_mul
    import vedic_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned K  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    vedic_seq_mul_if.slave bus,
    output logic           busy
);
    localparam int unsigned DW     = K * CW;
    localparam int unsigned PASSES = pass_count(K);
    localparam int unsigned IW     = idx_width(K);
    localparam logic [IW-1:0] LAST = IW'(PASSES - 1);

    state_t          r_state;
    logic [DW-1:0]   r_a, r_b;
    logic [2*DW-1:0] r_acc;
    logic [IW-1:0]   r_idx;
    logic            r_in_ready, r_out_valid, r_busy;

    int unsigned     w_i, w_j;
    logic [CW-1:0]   w_da, w_db;
    logic [2*CW-1:0] w_core_p;
    logic [2*DW-1:0] w_term;

    // i walks the multiplicand digits (outer), j the multiplier digits (inner)
    always_comb begin
        w_i    = 32'(r_idx) / K;
        w_j    = 32'(r_idx) % K;
        w_da   = CW'(r_a >> (w_i * CW));
        w_db   = CW'(r_b >> (w_j * CW));
        w_term = (2*DW)'(w_core_p) << ((w_i + w_j) * CW);
    end

    vedic_mul3x3 u_core (
        .i_a (w_da),
        .i_b (w_db),
        .o_p (w_core_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_acc <= r_acc + w_term;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.in_a;
                        r_b        <= bus.in_b;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_state    <= ST_MUL;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_p     = r_acc;
    assign busy          = r_busy;
endmodule

// File: tb/tb_vedic_seq_mul.sv
// Scoreboard bench for vedic_seq_mul: expected products are queued at accept
// and a monitor compares them as the DUT hands products downstream.
module tb_vedic_seq_mul;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    vedic_seq_mul_if #(.DW(6)) bus ();

    vedic_seq_mul #(.CW(3), .K(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [11:0] exp_q[$];
    int          pop_cyc[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic fail(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Monitor: a product transfers at the next rising edge when valid&ready.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_product: got %0d, required none", bus.out_p);
            end else begin
                chk("product", bus.out_p, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [5:0] a, input logic [5:0] b, input bit track);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail("accept_timeout");
        else if (track) exp_q.push_back(12'(a) * 12'(b));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [5:0] a, input logic [5:0] b);
        int n = 0;
        send(a, b, 1'b1);
        bus.in_valid = 1'b0;
        chk("busy_in_mul", busy, 1);
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, 4);
        chk("direct_product", bus.out_p, 12'(a) * 12'(b));
        @(posedge clk);
        #1;
        chk("valid_pulse", bus.out_valid, 0);
        chk("ready_back", bus.in_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_p", bus.out_p, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(6'd45, 6'd27);
        run_one(6'd0, 6'd63);
        run_one(6'd63, 6'd0);
        run_one(6'd1, 6'd1);
        run_one(6'd63, 6'd63);

        // Backpressure: product must hold while the consumer stalls.
        begin
            int n = 0;
            bus.out_ready = 1'b0;
            send(6'd5, 6'd7, 1'b1);
            bus.in_valid = 1'b0;
            while (!bus.out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_latency", n, 4);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_a     = 6'($urandom);
                bus.in_b     = 6'($urandom);
                #3;
                chk("bp_valid", bus.out_valid, 1);
                chk("bp_hold", bus.out_p, 35);
                chk("bp_in_ready", bus.in_ready, 0);
            end
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_release_busy", busy, 0);
            chk("bp_release_ready", bus.in_ready, 1);
        end

        // Reset during the second MUL cycle aborts the operation.
        send(6'd50, 6'd50, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_p", bus.out_p, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        run_one(6'd3, 6'd4);

        // Back-to-back with in_valid held high.
        drain();
        pop_cyc.delete();
        send(6'd10, 6'd10, 1'b1);
        send(6'd63, 6'd1, 1'b1);
        send(6'd33, 6'd22, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        chk("b2b_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            chk("b2b_gap0", pop_cyc[1] - pop_cyc[0], 6);
            chk("b2b_gap1", pop_cyc[2] - pop_cyc[1], 6);
        end

        // Random operands with random consumer stalls and source gaps.
        begin
            int  sent  = 0;
            int  guard = 0;
            bit  taken = 1'b0;
            while (sent < 1000 && guard < 60000) begin
                @(negedge clk);
                guard++;
                bus.out_ready = ($urandom_range(0, 3) != 0);
                if (taken) begin
                    taken        = 1'b0;
                    bus.in_valid = 1'b0;
                end
                if (!bus.in_valid && $urandom_range(0, 1) == 1) begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = 6'($urandom);
                    bus.in_b     = 6'($urandom);
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(12'(bus.in_a) * 12'(bus.in_b));
                    sent++;
                    taken = 1'b1;
                end
            end
            chk("rand_sent", sent, 1000);
            @(negedge clk);
            bus.in_valid = 1'b0;
            guard = 0;
            while (exp_q.size() != 0 && guard < 2000) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                guard++;
            end
            bus.out_ready = 1'b1;
            drain();
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
